// File: rtl/instr_fetch_queue.sv
// Instruction prefetch queue feeding the IF/ID register.
// Issues sequential word fetches over a valid/ready channel, buffers in-order
// responses in a small FIFO and presents the head {instr, pc}. A Flush
// redirects fetch, empties the queue and discards responses still in flight.
module instr_fetch_queue #(
  parameter int unsigned            ADDR_WIDTH  = 32,
  parameter int unsigned            INSTR_WIDTH = 32,
  parameter int unsigned            DEPTH       = 4,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   Stall,
  input  logic                   Flush,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic                   imem_req_valid,
  output logic [ADDR_WIDTH-1:0]  imem_req_addr,
  input  logic                   imem_req_ready,
  input  logic                   imem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
  output logic                   instr_valid,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [ADDR_WIDTH-1:0]  pc_out
);

  localparam int unsigned           PTR_W   = $clog2(DEPTH);
  localparam int unsigned           CNT_W   = PTR_W + 1;
  localparam logic [CNT_W:0]        DEPTH_S = (CNT_W + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] STEP    = ADDR_WIDTH'(4);

  // r_run keeps requests off until the first edge with rst_n sampled high
  logic                   r_run;
  logic [ADDR_WIDTH-1:0]  r_fetch_pc;
  logic [ADDR_WIDTH-1:0]  r_rsp_pc;
  logic [INSTR_WIDTH-1:0] r_fifo_instr [DEPTH];
  logic [ADDR_WIDTH-1:0]  r_fifo_pc    [DEPTH];
  // Pointers carry a wrap bit above the index bits
  logic [CNT_W-1:0]       r_rd_ptr;
  logic [CNT_W-1:0]       r_wr_ptr;
  logic [CNT_W-1:0]       r_count;
  logic [CNT_W-1:0]       r_pend;
  logic [CNT_W-1:0]       r_drop;

  logic                   w_room_fifo;
  logic                   w_room_flight;
  logic                   w_fire;
  logic                   w_rsp_keep;
  logic                   w_rsp_drop;
  logic                   w_pop;
  logic [PTR_W-1:0]       w_rd_idx;
  logic [PTR_W-1:0]       w_wr_idx;
  logic [ADDR_WIDTH-1:0]  w_redirect_aligned;

  // Request gating, response classification and head presentation
  always_comb begin
    w_rd_idx           = r_rd_ptr[PTR_W-1:0];
    w_wr_idx           = r_wr_ptr[PTR_W-1:0];
    w_redirect_aligned = redirect_pc & ~ADDR_WIDTH'(3);
    // Slots are reserved at request time, so a kept response never overflows
    w_room_fifo        = ({1'b0, r_count} + {1'b0, r_pend}) < DEPTH_S;
    w_room_flight      = ({1'b0, r_pend} + {1'b0, r_drop}) < DEPTH_S;
    imem_req_valid     = r_run && !Flush && w_room_fifo && w_room_flight;
    imem_req_addr      = r_fetch_pc;
    w_fire             = imem_req_valid && imem_req_ready;
    w_rsp_keep         = imem_rsp_valid && !Flush && (r_drop == '0);
    w_rsp_drop         = imem_rsp_valid && (r_drop != '0);
    instr_valid        = (r_count != '0);
    w_pop              = instr_valid && !Stall && !Flush;
    instr_out          = instr_valid ? r_fifo_instr[w_rd_idx] : '0;
    pc_out             = instr_valid ? r_fifo_pc[w_rd_idx] : '0;
  end

  // Control state: fetch/response PCs, pointers and occupancy counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_run      <= 1'b0;
      r_fetch_pc <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_pend     <= '0;
      r_drop     <= '0;
    end else begin
      r_run <= 1'b1;
      if (Flush) begin
        r_fetch_pc <= w_redirect_aligned;
        r_rsp_pc   <= w_redirect_aligned;
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
        r_count    <= '0;
        // Every live request becomes stale; a response this cycle retires one of them
        r_drop     <= r_drop + r_pend - CNT_W'(imem_rsp_valid);
        r_pend     <= '0;
      end else begin
        if (w_fire) begin
          r_fetch_pc <= r_fetch_pc + STEP;
        end
        if (w_rsp_keep) begin
          r_rsp_pc <= r_rsp_pc + STEP;
          r_wr_ptr <= r_wr_ptr + CNT_W'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + CNT_W'(1);
        end
        r_pend  <= r_pend + CNT_W'(w_fire) - CNT_W'(w_rsp_keep);
        r_drop  <= r_drop - CNT_W'(w_rsp_drop);
        r_count <= r_count + CNT_W'(w_rsp_keep) - CNT_W'(w_pop);
      end
    end
  end

  // FIFO storage; contents are only meaningful while counted
  always_ff @(posedge clk) begin
    if (w_rsp_keep) begin
      r_fifo_instr[w_wr_idx] <= imem_rsp_data;
      r_fifo_pc[w_wr_idx]    <= r_rsp_pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: queue-based reference model checked every cycle,
// a flush/redirect vector table, and directed stall/flush/reset sequences.
module tb_instr_fetch_queue;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] KEY    = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Stall;
  logic        Flush;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:0] pc_out;

  always #5 clk = ~clk;

  instr_fetch_queue #(
    .ADDR_WIDTH (32),
    .INSTR_WIDTH(32),
    .DEPTH      (DEPTH),
    .RESET_PC   (RST_PC)
  ) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .Stall         (Stall),
    .Flush         (Flush),
    .redirect_pc   (redirect_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr (imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .instr_valid   (instr_valid),
    .instr_out     (instr_out),
    .pc_out        (pc_out)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: in-flight requests (stale after a flush) and queued entries
  typedef struct { logic [31:0] pc; bit stale; } infl_t;
  typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  infl_t       m_infl[$];
  ent_t        m_fifo[$];
  mreq_t       mem_q[$];
  logic [31:0] m_fetch_pc = '0;
  bit          m_run      = 1'b0;
  bit          m_init     = 1'b0;
  bit          exp_req;
  int          cyc        = 0;
  int          mem_lat    = 1;
  bit          last_fire;
  logic [31:0] last_addr;

  function automatic int live_cnt();
    int n;
    n = 0;
    foreach (m_infl[i]) if (!m_infl[i].stale) n++;
    return n;
  endfunction

  task automatic model_update();
    infl_t f;
    bit    had;
    if (!rst_n) begin
      m_infl.delete();
      m_fifo.delete();
      m_fetch_pc = RST_PC;
      m_run      = 1'b0;
      m_init     = 1'b1;
    end else begin
      if (Flush) begin
        if (imem_rsp_valid && m_infl.size() > 0) void'(m_infl.pop_front());
        foreach (m_infl[i]) m_infl[i].stale = 1'b1;
        m_fifo.delete();
        m_fetch_pc = redirect_pc & ~32'h3;
      end else begin
        had = (m_fifo.size() > 0);
        if (had && !Stall) void'(m_fifo.pop_front());
        if (imem_rsp_valid && m_infl.size() > 0) begin
          f = m_infl.pop_front();
          if (!f.stale) m_fifo.push_back('{f.pc, imem_rsp_data});
        end
        if (exp_req && imem_req_ready) begin
          m_infl.push_back('{m_fetch_pc, 1'b0});
          m_fetch_pc = m_fetch_pc + 32'd4;
        end
      end
      m_run = 1'b1;
    end
  endtask

  // Memory: fixed latency, in order, one response per cycle, data = addr ^ KEY
  task automatic mem_update();
    mreq_t r;
    if (!rst_n) begin
      mem_q.delete();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      return;
    end
    if (last_fire) mem_q.push_back('{last_addr, cyc + mem_lat});
    if (mem_q.size() > 0 && mem_q[0].due <= cyc + 1) begin
      r = mem_q.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = r.addr ^ KEY;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  endtask

  // One clock: compare outputs at negedge, advance model and memory after posedge
  task automatic step();
    @(negedge clk);
    exp_req = m_run && !Flush && ((m_fifo.size() + live_cnt()) < DEPTH) &&
              (m_infl.size() < DEPTH);
    if (m_init) begin
      chk("instr_valid", 32'(instr_valid), 32'(m_fifo.size() != 0));
      chk("instr_out", instr_out, (m_fifo.size() != 0) ? m_fifo[0].ins : 32'h0);
      chk("pc_out", pc_out, (m_fifo.size() != 0) ? m_fifo[0].pc : 32'h0);
      chk("req_valid", 32'(imem_req_valid), 32'(exp_req));
      chk("req_addr", imem_req_addr, m_fetch_pc);
    end
    last_fire = imem_req_valid && imem_req_ready;
    last_addr = imem_req_addr;
    @(posedge clk);
    #1;
    cyc++;
    model_update();
    mem_update();
  endtask

  typedef struct {
    logic [31:0] redir;
    int          lat;
    logic [31:0] exp_a0;
    logic [31:0] exp_a1;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] h;
    logic [31:0] a0;
    logic [31:0] a1;
    int          nv;
    int          nf;
    bit          got;

    vecs[0] = '{32'h0000_2003, 3, 32'h0000_2000, 32'h0000_2004};
    vecs[1] = '{32'hFFFF_FFFE, 1, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[2] = '{32'h0000_0101, 2, 32'h0000_0100, 32'h0000_0104};
    vecs[3] = '{32'h8000_0005, 1, 32'h8000_0004, 32'h8000_0008};

    rst_n          = 1'b0;
    Stall          = 1'b0;
    Flush          = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;

    step();
    step();
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("rst_instr_valid", 32'(instr_valid), 32'h0);
    chk("rst_instr_out", instr_out, 32'h0);
    chk("rst_pc_out", pc_out, 32'h0);
    rst_n = 1'b1;

    // Steady state, 1-cycle memory: one instruction every cycle
    repeat (4) step();
    nv = 0;
    for (int i = 0; i < 16; i++) begin
      if (instr_valid) nv++;
      step();
    end
    chk("steady_throughput", 32'(nv), 32'd16);

    // Stall until the queue fills, then drain in order
    Stall = 1'b1;
    h = m_fifo[0].pc;
    repeat (10) step();
    chk("stall_req_blocked", 32'(imem_req_valid), 32'h0);
    chk("stall_head_pc", pc_out, h);
    chk("stall_head_instr", instr_out, h ^ KEY);
    Stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", pc_out, h + 32'(4 * i));
      step();
    end
    chk("resume_req", 32'(imem_req_valid), 32'h1);

    // Flush/redirect vectors with requests in flight
    foreach (vecs[v]) begin
      mem_lat = vecs[v].lat;
      Stall   = 1'b0;
      repeat (6) step();
      Flush       = 1'b1;
      redirect_pc = vecs[v].redir;
      step();
      Flush       = 1'b0;
      Stall       = 1'b1;
      redirect_pc = $urandom;
      nf = 0;
      a0 = 32'hDEAD_BEEF;
      a1 = 32'hDEAD_BEEF;
      for (int t = 0; t < 40 && (nf < 2 || !instr_valid); t++) begin
        step();
        if (last_fire) begin
          if (nf == 0) a0 = last_addr;
          else if (nf == 1) a1 = last_addr;
          nf++;
        end
      end
      chk("redir_addr0", a0, vecs[v].exp_a0);
      chk("redir_addr1", a1, vecs[v].exp_a1);
      chk("redir_first_pc", pc_out, vecs[v].exp_a0);
      chk("redir_first_instr", instr_out, vecs[v].exp_a0 ^ KEY);
      Stall = 1'b0;
    end

    // Flush coinciding with a response and Stall
    mem_lat = 2;
    repeat (5) step();
    for (int t = 0; t < 20 && !imem_rsp_valid; t++) step();
    Flush       = 1'b1;
    Stall       = 1'b1;
    redirect_pc = 32'h0000_0300;
    step();
    Flush = 1'b0;
    chk("flush_rsp_ivalid", 32'(instr_valid), 32'h0);
    chk("flush_rsp_instr", instr_out, 32'h0);
    chk("flush_rsp_pc", pc_out, 32'h0);
    chk("flush_next_addr", imem_req_addr, 32'h0000_0300);
    Stall = 1'b0;

    // Randomised traffic against the model
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) mem_lat = int'($urandom_range(1, 3));
      imem_req_ready = ($urandom_range(0, 1) == 1);
      Stall          = ($urandom_range(0, 3) == 0);
      Flush          = ($urandom_range(0, 29) == 0);
      redirect_pc    = $urandom;
      step();
    end
    Flush          = 1'b0;
    Stall          = 1'b0;
    imem_req_ready = 1'b1;

    // Reset pulsed mid-stream
    mem_lat = 1;
    repeat (5) step();
    rst_n = 1'b0;
    step();
    chk("mid_rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("mid_rst_instr_valid", 32'(instr_valid), 32'h0);
    chk("mid_rst_instr_out", instr_out, 32'h0);
    chk("mid_rst_pc_out", pc_out, 32'h0);
    rst_n = 1'b1;
    got = 1'b0;
    a0  = 32'hDEAD_BEEF;
    for (int t = 0; t < 10 && !got; t++) begin
      step();
      if (last_fire) begin
        got = 1'b1;
        a0  = last_addr;
      end
    end
    chk("restart_fire", 32'(got), 32'h1);
    chk("restart_addr", a0, RST_PC);
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
